// File: rtl/vga_pixel_gen_if.sv
// rtl/vga_pixel_gen_if.sv - framebuffer read port between pixel generator and video RAM
interface vga_pixel_gen_if;
    logic [16:0] fb_addr;
    logic        fb_rd_en;
    logic [11:0] fb_rdata;

    modport master (output fb_addr, output fb_rd_en, input fb_rdata);
    modport slave  (input fb_addr, input fb_rd_en, output fb_rdata);
endinterface

// File: rtl/vga_pixel_gen.sv
// rtl/vga_pixel_gen.sv - 3-stage VGA pixel pipeline: framebuffer fetch or test patterns, delayed syncs
module vga_pixel_gen (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic                   displaying_in,
    input  logic [9:0]             x_in,
    input  logic [9:0]             y_in,
    input  logic [1:0]             mode,
    vga_pixel_gen_if.master        fb,
    output logic                   hsync_n,
    output logic                   vsync_n,
    output logic [3:0]             r,
    output logic [3:0]             g,
    output logic [3:0]             b,
    output logic                   frame_start,
    output logic [7:0]             frame_count
);
    localparam int LATENCY = 3;

    logic [LATENCY-1:0] hs_sr, vs_sr, disp_sr;
    logic [1:0]         mode_active;
    logic               vsync_prev;
    logic               vsync_rise;
    logic [16:0]        addr_calc;
    logic [16:0]        y_half;
    logic [11:0]        bar_rgb;
    logic [11:0]        pat_rgb;
    logic [11:0]        pat_d1, pat_d2;
    logic               src_fb_d1, src_fb_d2;
    logic               unused_bits;

    assign unused_bits = y_in[0];
    assign vsync_rise  = vsync_in & ~vsync_prev;

    // 320 = 256 + 64, so row offset is two shifted copies of y/2
    assign y_half    = {8'd0, y_in[9:1]};
    assign addr_calc = (y_half << 8) + (y_half << 6) + {8'd0, x_in[9:1]};

    always_comb begin
        bar_rgb = 12'h000;
        if      (x_in < 10'd80)  bar_rgb = 12'hFFF;
        else if (x_in < 10'd160) bar_rgb = 12'hFF0;
        else if (x_in < 10'd240) bar_rgb = 12'h0FF;
        else if (x_in < 10'd320) bar_rgb = 12'h0F0;
        else if (x_in < 10'd400) bar_rgb = 12'hF0F;
        else if (x_in < 10'd480) bar_rgb = 12'hF00;
        else if (x_in < 10'd560) bar_rgb = 12'h00F;
        else                     bar_rgb = 12'h000;
    end

    always_comb begin
        pat_rgb = 12'h000;
        case (mode_active)
            2'b01:   pat_rgb = bar_rgb;
            2'b10:   pat_rgb = {12{x_in[5] ^ y_in[5]}};
            2'b11:   pat_rgb = {x_in[7:4], y_in[7:4], frame_count[5:2]};
            default: pat_rgb = 12'h000;
        endcase
    end

    assign hsync_n = ~hs_sr[LATENCY-1];
    assign vsync_n = ~vs_sr[LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_sr       <= '0;
            vs_sr       <= '0;
            disp_sr     <= '0;
            vsync_prev  <= 1'b0;
            mode_active <= 2'b00;
            frame_start <= 1'b0;
            frame_count <= 8'd0;
            fb.fb_addr  <= 17'd0;
            fb.fb_rd_en <= 1'b0;
            pat_d1      <= 12'h000;
            pat_d2      <= 12'h000;
            src_fb_d1   <= 1'b0;
            src_fb_d2   <= 1'b0;
            r           <= 4'h0;
            g           <= 4'h0;
            b           <= 4'h0;
        end else begin
            hs_sr      <= {hs_sr[LATENCY-2:0], hsync_in};
            vs_sr      <= {vs_sr[LATENCY-2:0], vsync_in};
            disp_sr    <= {disp_sr[LATENCY-2:0], displaying_in};
            vsync_prev <= vsync_in;

            // Mode only switches at the vsync edge, which sits deep in blanking
            frame_start <= vsync_rise;
            if (vsync_rise) begin
                frame_count <= frame_count + 8'd1;
                mode_active <= mode;
            end

            // S1: read request and pattern colour
            fb.fb_rd_en <= displaying_in && (mode_active == 2'b00);
            if (displaying_in && (mode_active == 2'b00))
                fb.fb_addr <= addr_calc;
            pat_d1    <= pat_rgb;
            src_fb_d1 <= (mode_active == 2'b00);

            // S2: RAM returns data; pattern rides along
            pat_d2    <= pat_d1;
            src_fb_d2 <= src_fb_d1;

            // S3: colour select, blanked outside active area
            if (!disp_sr[LATENCY-2]) begin
                {r, g, b} <= 12'h000;
            end else if (src_fb_d2) begin
                {r, g, b} <= fb.fb_rdata;
            end else begin
                {r, g, b} <= pat_d2;
            end
        end
    end
endmodule
